// File: rtl/music_pkg.sv
// Shared definitions for the music datapath: allocator state encodings and the
// note/duration field widths used by song_reader, voice_allocator and note_player.
package music_pkg;

    typedef enum logic [1:0] {
        VA_IDLE  = 2'd0,
        VA_ALLOC = 2'd1,
        VA_FULL  = 2'd2
    } va_state_t;

    localparam int NOTE_WIDTH = 6;
    localparam int DUR_WIDTH  = 6;

    // Population count for masks of up to eight voices.
    function automatic int unsigned count_ones(input logic [7:0] v);
        count_ones = 0;
        for (int i = 0; i < 8; i++) begin
            count_ones += {31'd0, v[i]};
        end
    endfunction

endpackage

// File: rtl/rr_free_finder.sv
// Combinational round-robin search: finds the first clear bit of a busy mask,
// starting at a given pointer and wrapping from NUM-1 back to 0.
module rr_free_finder #(
    parameter int NUM   = 4,
    parameter int PTR_W = 2
) (
    input  logic [NUM-1:0]   busy,
    input  logic [PTR_W-1:0] start,
    output logic             found,
    output logic [PTR_W-1:0] index
);

    int               cand;
    logic [PTR_W-1:0] cidx;

    always_comb begin
        found = 1'b0;
        index = start;
        cand  = 0;
        cidx  = '0;
        for (int off = 0; off < NUM; off++) begin
            cand = int'(start) + off;
            if (cand >= NUM) begin
                cand = cand - NUM;
            end
            cidx = PTR_W'(cand);
            if (!found && !busy[cidx]) begin
                found = 1'b1;
                index = cidx;
            end
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Polyphony scheduler: hands each song_reader note to a free voice round-robin.
// Define VOICE_ALLOCATOR_STEAL_EN to steal voice rr_ptr instead of waiting when all are busy.
module voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int NOTE_WIDTH = music_pkg::NOTE_WIDTH,
    parameter int DUR_WIDTH  = music_pkg::DUR_WIDTH
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                flush,
    input  logic                                play,
    input  logic                                new_note,
    input  logic [NOTE_WIDTH-1:0]               note,
    input  logic [DUR_WIDTH-1:0]                duration,
    input  logic [NUM_VOICES-1:0]               voice_done,
`ifdef VOICE_ALLOCATOR_STEAL_EN
    output logic                                voice_stolen,
`endif
    output logic                                note_accepted,
    output logic [NUM_VOICES-1:0]               load_voice,
    output logic [NOTE_WIDTH-1:0]               note_to_load,
    output logic [DUR_WIDTH-1:0]                duration_to_load,
    output logic [NUM_VOICES-1:0]               voice_busy,
    output logic [$clog2(NUM_VOICES+1)-1:0]     busy_count
);
    import music_pkg::*;

    localparam int PTR_W = $clog2(NUM_VOICES);
    localparam int CNT_W = $clog2(NUM_VOICES + 1);

    va_state_t             state;
    logic [PTR_W-1:0]      rr_ptr;
    logic [NOTE_WIDTH-1:0] note_lat;
    logic [DUR_WIDTH-1:0]  dur_lat;

    logic                  free_found;
    logic [PTR_W-1:0]      free_idx;
    logic [PTR_W-1:0]      load_idx;
    logic [PTR_W-1:0]      next_ptr;
    logic                  do_load;
    logic                  steal;
    logic [NUM_VOICES-1:0] load_mask;
    logic [NUM_VOICES-1:0] busy_next;

    rr_free_finder #(
        .NUM   (NUM_VOICES),
        .PTR_W (PTR_W)
    ) u_free_finder (
        .busy  (voice_busy),
        .start (rr_ptr),
        .found (free_found),
        .index (free_idx)
    );

    // A pending request is only served while play is high; a load always beats a
    // same-cycle done strobe on the same voice.
    always_comb begin
        do_load  = 1'b0;
        steal    = 1'b0;
        load_idx = free_idx;
        if (state == VA_ALLOC && play) begin
            if (free_found) begin
                do_load = 1'b1;
            end
`ifdef VOICE_ALLOCATOR_STEAL_EN
            else begin
                do_load  = 1'b1;
                steal    = 1'b1;
                load_idx = rr_ptr;
            end
`endif
        end
        load_mask = do_load ? (NUM_VOICES'(1) << load_idx) : '0;
        busy_next = (voice_busy & ~voice_done) | load_mask;
        next_ptr  = (load_idx == PTR_W'(NUM_VOICES - 1)) ? '0 : load_idx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state            <= VA_IDLE;
            note_lat         <= '0;
            dur_lat          <= '0;
            note_accepted    <= 1'b0;
            load_voice       <= '0;
            note_to_load     <= '0;
            duration_to_load <= '0;
            voice_busy       <= '0;
            busy_count       <= '0;
`ifdef VOICE_ALLOCATOR_STEAL_EN
            voice_stolen     <= 1'b0;
`endif
            if (reset) begin
                rr_ptr <= '0;
            end
        end else begin
            note_accepted <= do_load;
            load_voice    <= load_mask;
            voice_busy    <= busy_next;
            busy_count    <= CNT_W'(count_ones(8'(busy_next)));
`ifdef VOICE_ALLOCATOR_STEAL_EN
            voice_stolen  <= steal;
`endif
            if (do_load) begin
                note_to_load     <= note_lat;
                duration_to_load <= dur_lat;
                rr_ptr           <= next_ptr;
            end
            case (state)
                VA_IDLE: begin
                    if (new_note && play) begin
                        note_lat <= note;
                        dur_lat  <= duration;
                        state    <= VA_ALLOC;
                    end
                end
                VA_ALLOC: begin
                    if (do_load) begin
                        state <= VA_IDLE;
                    end else if (play) begin
                        state <= VA_FULL;
                    end
                end
                VA_FULL: begin
                    if (|(voice_done & voice_busy)) begin
                        state <= VA_ALLOC;
                    end
                end
                default: state <= VA_IDLE;
            endcase
        end
    end

endmodule
